// File: rtl/kgp_risc_boot_loader.sv
// Boot loader: receives a length-prefixed big-endian byte image, writes 32-bit words into
// instruction memory from address 0, and holds the KGP-RISC core in reset until loading is done.
module kgp_risc_boot_loader #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StHold,
        StRun,
        StErr
    } state_e;

    localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

    state_e              state_q, state_d;
    logic                armed_q;
    logic                core_rst_q;
    logic [7:0]          n_hi_q;
    logic [15:0]         n_q;
    logic [15:0]         n_new;
    logic [1:0]          byte_idx_q;
    logic [23:0]         word_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     wl_q;
    logic [7:0]          hold_cnt_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [DATA_W-1:0]   imem_wdata_q;
    logic                xfer;
    logic                last_word;

    assign n_new     = {n_hi_q, in_data};
    assign xfer      = in_valid & in_ready;
    assign last_word = (17'(wl_q) + 17'd1) == {1'b0, n_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StLenHi;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StLenHi: begin
                in_ready = armed_q;
                if (xfer) state_d = StLenLo;
            end
            StLenLo: begin
                in_ready = armed_q;
                if (xfer) begin
                    if (n_new == 16'd0) begin
                        state_d = StHold;
                    end else if ({1'b0, n_new} > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = armed_q;
                if (xfer && byte_idx_q == 2'd3) state_d = StWrite;
            end
            StWrite: state_d = last_word ? StHold : StData;
            StHold: begin
                if (hold_cnt_q == 8'(HOLD_CYC - 1)) state_d = StRun;
            end
            StRun: begin
                if (reload) state_d = StLenHi;
            end
            StErr: begin
                if (reload) state_d = StLenHi;
            end
            default: state_d = StLenHi;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q      <= 1'b0;
            core_rst_q   <= 1'b1;
            n_hi_q       <= '0;
            n_q          <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            wl_q         <= '0;
            hold_cnt_q   <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            armed_q    <= 1'b1;
            // Registered from next state so core_rst is glitch-free and aligned with RUN.
            core_rst_q <= (state_d != StRun);
            hold_cnt_q <= (state_q == StHold) ? hold_cnt_q + 8'd1 : 8'd0;

            if (state_q == StLenHi && xfer) n_hi_q <= in_data;

            if (state_q == StLenLo && xfer) begin
                n_q        <= n_new;
                byte_idx_q <= '0;
                addr_q     <= '0;
                wl_q       <= '0;
            end

            if (state_q == StData && xfer) begin
                word_q     <= {word_q[15:0], in_data};
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    imem_wdata_q <= {word_q, in_data};
                    imem_addr_q  <= addr_q;
                end
            end

            if (state_q == StWrite) begin
                addr_q     <= addr_q + 1'b1;
                wl_q       <= wl_q + 1'b1;
                byte_idx_q <= '0;
            end

            if ((state_q == StRun || state_q == StErr) && reload) begin
                addr_q <= '0;
                wl_q   <= '0;
            end
        end
    end

    assign imem_we      = (state_q == StWrite);
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rst     = core_rst_q;
    assign load_done    = (state_q == StRun);
    assign load_err     = (state_q == StErr);
    assign words_loaded = wl_q;

endmodule

// File: doc/kgp_risc_boot_loader.md
Name: kgp_risc_boot_loader

Overview:
Writer-side counterpart to the KGP-RISC core's instruction fetch. It receives a program image as a byte stream over a valid/ready interface, assembles 32-bit words, and writes them sequentially into instruction memory starting at address 0. It holds the core in reset (active-high core_rst, as the core expects) until the image is fully written, then releases it. It sits between the board/host link and the KGP_RISC top.

Parameters:
ADDR_W, 10, instruction memory word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word
HOLD_CYC, 4, cycles core_rst stays high after the last write before release; range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
reload  input  1  single-cycle pulse: restart load from header; honoured only in RUN or ERR
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
core_rst  output  1  active-high reset to KGP_RISC core
load_done  output  1  high while in RUN
load_err  output  1  high while in ERR
words_loaded  output  ADDR_W+1  count of words written in current load

Behaviour:
- Reset (rst=0, async): state=LEN_HI; core_rst=1; in_ready=0 until first clk edge after release; imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, words_loaded=0.
- Frame format: 2-byte word count N, big-endian, followed by N words of 4 bytes each, big-endian (first byte = bits 31:24).
- States:
  - LEN_HI: in_ready=1; on transfer latch N[15:8] and go to LEN_LO.
  - LEN_LO: in_ready=1; on transfer latch N[7:0]. If N=0, go to HOLD. If N>2**ADDR_W, go to ERR. Otherwise go to DATA with byte_idx=0 and addr=0.
  - DATA: in_ready=1; each transfer shifts a byte into the word register and increments byte_idx. The transfer at byte_idx=3 goes to WRITE.
  - WRITE: one cycle; in_ready=0; imem_we=1 with imem_addr=addr and the assembled word on imem_wdata; words_loaded increments. Then addr increments. If words_loaded reaches N, go to HOLD; else go to DATA with byte_idx=0.
  - HOLD: in_ready=0; core_rst=1 for exactly HOLD_CYC cycles, then go to RUN.
  - RUN: core_rst=0, load_done=1, in_ready=0. reload goes to LEN_HI, sets core_rst=1 on the next edge, and clears words_loaded/addr.
  - ERR: core_rst=1, load_err=1, in_ready=0. reload goes to LEN_HI and clears load_err.
- imem_we is high only in WRITE. imem_addr/imem_wdata hold their last values otherwise.
- Latency: imem_we is asserted the cycle after the 4th byte transfer. Minimum 5 cycles per word at full stream rate.
- A gap in in_valid mid-word stalls the loader with no state loss. Byte boundaries are never lost.
- reload outside RUN/ERR is ignored.
- An async reset mid-load aborts immediately to reset values. No partial-word write occurs.
- core_rst is registered and glitch-free. It is never low outside RUN.
- N=2**ADDR_W is legal: the final address is 2**ADDR_W−1, and addr wrap after the last write is don't-care.

Test Plan:
- Reset then N=2, bytes 00 02 | 12 34 56 78 | 9A BC DE F0 at one byte/cycle -> imem_we pulses with (addr 0, 0x12345678) then (addr 1, 0x9ABCDEF0); words_loaded=2; core_rst falls exactly HOLD_CYC=4 cycles after the second write; load_done=1.
- Same image with in_valid toggling 1/0 each cycle -> identical memory writes and final state; in_ready is 0 only in WRITE/HOLD/RUN.
- Header 00 00 -> no imem_we; core_rst released after 4 cycles; words_loaded=0.
- Header 04 01 with ADDR_W=10 (N=1025) -> ERR, load_err=1, core_rst=1, in_ready=0; a reload pulse returns to LEN_HI with load_err=0.
- In RUN, pulse reload and send 00 01 | DE AD BE EF -> core_rst=1 the next cycle; write 0xDEADBEEF at addr 0; core released again.
- Assert rst=0 after 2 bytes of a word -> outputs return to reset values asynchronously with no imem_we; after release a full new frame loads correctly from addr 0.
